// File: rtl/a_pkg.sv
// Shared constants, state encoding and row type for the abv packer.
package a_pkg;

  localparam int AUM_DEF = 80;
  localparam int BUM_DEF = 70;
  localparam int VUM_DEF = 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_t;

  typedef logic [BUM_DEF-1:0] abv_row_t;

  // A counter for n values needs at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a_abv_packer_if.sv
// Beat-in / frame-out handshake bundle between a beat source, the packer and its consumer.
interface a_abv_packer_if
  import a_pkg::*;
#(
  parameter int AUM = AUM_DEF,
  parameter int BUM = BUM_DEF,
  parameter int VUM = VUM_DEF
);

  logic                      in_valid;
  logic                      in_ready;
  logic [BUM-1:0]            in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [AUM-1:0][BUM-1:0]   my_data_abv [VUM];

  // Packer view: consumes beats, produces frames.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, my_data_abv
  );

  // Environment view: drives beats and the frame ready.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, my_data_abv
  );

endinterface

// File: rtl/a_abv_beat_ctr.sv
// Two-level beat/lane position counter; clr has priority over inc.
module a_abv_beat_ctr
  import a_pkg::*;
#(
  parameter int  AUM = AUM_DEF,
  parameter int  VUM = VUM_DEF,
  localparam int BW  = cnt_width(AUM),
  localparam int LW  = cnt_width(VUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [BW-1:0] beat_cnt,
  output logic [LW-1:0] lane_cnt,
  output logic          at_end
);

  logic [BW-1:0] beat_cnt_r;
  logic [LW-1:0] lane_cnt_r;
  logic          beat_last_s;
  logic          lane_last_s;

  assign beat_last_s = (beat_cnt_r == BW'(AUM - 1));
  assign lane_last_s = (lane_cnt_r == LW'(VUM - 1));

  // Advance beat position, rolling into the next lane after the last row.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      beat_cnt_r <= {BW{1'b0}};
      lane_cnt_r <= {LW{1'b0}};
    end else if (inc) begin
      if (beat_last_s) begin
        beat_cnt_r <= {BW{1'b0}};
        lane_cnt_r <= lane_last_s ? {LW{1'b0}} : lane_cnt_r + LW'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r + BW'(1);
      end
    end
  end

  assign beat_cnt = beat_cnt_r;
  assign lane_cnt = lane_cnt_r;
  assign at_end   = beat_last_s && lane_last_s;

endmodule

// File: rtl/a_abv_packer.sv
// Packs BUM-bit beats into VUM lanes of AUM rows and hands the frame off with valid/ready.
module a_abv_packer
  import a_pkg::*;
#(
  parameter int AUM = AUM_DEF,
  parameter int BUM = BUM_DEF,
  parameter int VUM = VUM_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  a_abv_packer_if.slave   bus,
  output logic            err_early_last,
  output logic            err_missing_last
);

  localparam int BW = cnt_width(AUM);
  localparam int LW = cnt_width(VUM);

  packer_state_t           state_r;
  packer_state_t           state_nxt_s;
  logic [AUM-1:0][BUM-1:0] buf_r [VUM];
  logic [BW-1:0]           beat_cnt_s;
  logic [LW-1:0]           lane_cnt_s;
  logic                    at_end_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    close_s;
  logic                    handoff_s;
  logic                    err_early_r;
  logic                    err_missing_r;

  // in_ready is gated by rst_n so it is low for the whole reset window.
  assign in_ready_s = rst_n && (state_r == FILL);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign close_s    = accept_s && (bus.in_last || at_end_s);
  assign handoff_s  = (state_r == FULL) && bus.out_ready;

  a_abv_beat_ctr #(
    .AUM (AUM),
    .VUM (VUM)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (accept_s && !close_s),
    .clr      (close_s),
    .beat_cnt (beat_cnt_s),
    .lane_cnt (lane_cnt_s),
    .at_end   (at_end_s)
  );

  // Next-state: close a frame on last/early-last beat, release it on handoff.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (close_s) state_nxt_s = FULL;
        else         state_nxt_s = FILL;
      end
      FULL: begin
        if (bus.out_ready) state_nxt_s = FILL;
        else               state_nxt_s = FULL;
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= FILL;
    else        state_r <= state_nxt_s;
  end

  // Error pulses line up with the first out_valid cycle of the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_early_r   <= 1'b0;
      err_missing_r <= 1'b0;
    end else begin
      err_early_r   <= accept_s && bus.in_last && !at_end_s;
      err_missing_r <= accept_s && at_end_s && !bus.in_last;
    end
  end

  // Frame buffer: cleared on handoff so rows skipped by an early last read as zero.
  always_ff @(posedge clk) begin
    if (!rst_n || handoff_s) begin
      for (int v = 0; v < VUM; v++) buf_r[v] <= '0;
    end else if (accept_s) begin
      for (int v = 0; v < VUM; v++) begin
        for (int r = 0; r < AUM; r++) begin
          if ((lane_cnt_s == LW'(v)) && (beat_cnt_s == BW'(r))) buf_r[v][r] <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = (state_r == FULL);
  assign bus.my_data_abv = buf_r;
  assign err_early_last   = err_early_r;
  assign err_missing_last = err_missing_r;

endmodule

// File: doc/a_abv_packer.md
# a_abv_packer

Transmit-side counterpart of module `a`. Accepts a narrow valid/ready stream of BUM-bit beats and assembles `VUM` lanes of `AUM` rows each into the `[AUM-1:0][BUM-1:0]` packed, `[VUM]` unpacked array that `a` consumes on `my_data_abv`. It then presents the completed frame with a valid/ready handshake. It sits between the upstream beat source and each `a` instance, one packer per instance (TEST0/TEST1 paths).

## Interface
Parameters:
- `AUM`, default 80: rows per lane, which is also beats per lane.
- `BUM`, default 70: bits per row and per input beat.
- `VUM`, default 1: lanes per frame.

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: packer can accept a beat.
- `in_data`, input, `[BUM-1:0]`: one row.
- `in_last`, input, 1: marks the final beat of a frame.
- `out_valid`, output, 1: frame complete and held.
- `out_ready`, input, 1: consumer accepts the frame.
- `my_data_abv`, output, `[AUM-1:0][BUM-1:0]`, `[VUM]`: the assembled frame.
- `err_early_last`, output, 1: one-cycle pulse when `in_last` arrives before the final beat.
- `err_missing_last`, output, 1: one-cycle pulse when the final beat arrives without `in_last`.

## Operation
- There are two states: `FILL` and `FULL`.
- `in_ready` is 1 in `FILL` and 0 in `FULL`. It is forced to 0 while `rst_n` is 0.
- A beat is accepted when `in_valid && in_ready`.
  - Beat *k* of the frame is written to `my_data_abv[lane_cnt][beat_cnt]`, where `lane_cnt = k / AUM` and `beat_cnt = k % AUM`.
  - `beat_cnt` counts 0..AUM-1. It wraps to 0 and increments `lane_cnt` when the accepted beat has `beat_cnt==AUM-1`.
- Normal end of frame: the accepted beat has `lane_cnt==VUM-1`, `beat_cnt==AUM-1` and `in_last==1`. The state goes to `FULL` and the counters go to 0.
- Final beat without `in_last`: same transition, plus a one-cycle pulse on `err_missing_last`. The frame is still presented.
- `in_last` on any earlier beat:
  - The beat is stored and the state goes to `FULL` with the counters cleared.
  - `err_early_last` pulses for one cycle.
  - Unwritten rows remain 0, because the buffer is cleared on every frame handoff.
- In `FULL`:
  - `out_valid` is 1.
  - `my_data_abv` is held stable until `out_ready`.
  - `in_data` and `in_valid` are ignored.
- Frame handoff (`out_valid && out_ready`) has the following effects on the next edge:
  - the state returns to `FILL`,
  - `out_valid` goes to 0,
  - the whole buffer is cleared to 0.
- There is no bypass: an input beat is never accepted in the same cycle as a handoff.
- Counter widths are `$clog2(AUM)` and `$clog2(VUM)`, each with a minimum of 1 bit. The counters never exceed AUM-1 / VUM-1.
- No arithmetic is done on the data; rows are stored bit-exact.

## Timing
- Reset values:
  - state `FILL`; counters 0; `my_data_abv` all 0;
  - `out_valid` 0; `err_early_last` 0; `err_missing_last` 0;
  - `in_ready` is 1 from the first cycle after `rst_n` goes high.
- Latency:
  - `out_valid` rises on the edge that accepts the closing beat (the last beat or an early `in_last`).
  - `in_ready` falls on that same edge.
- The error pulses are registered and are high in the same cycle that `out_valid` first goes high.
- Minimum frame period is `AUM*VUM + 1` cycles: the closing beat's edge sets `out_valid`, handoff needs one cycle in `FULL`, then `FILL` resumes.
- Reset asserted mid-frame: all state, data and errors return to their reset values on that edge. The partial frame is discarded and is never presented.
- Reset asserted while in `FULL`: the frame is dropped and `out_valid` is 0 on the next cycle.
- `out_ready` held high continuously: each frame is presented for exactly one cycle.

## Structure
- Package `a_pkg` contains:
  - `AUM_DEF`, `BUM_DEF`, `VUM_DEF` constants (80/70/1);
  - the state enum `packer_state_t` (`FILL`, `FULL`);
  - row typedef `abv_row_t` (`[BUM_DEF-1:0]`).
- One sub-module, `a_abv_beat_ctr`, implements the two-level beat/lane counter. It has inputs `inc` and `clr`, and outputs `beat_cnt`, `lane_cnt` and `at_end`.
- Everything else lives in the top module.

## Test plan
Bench parameters: `AUM=4`, `BUM=8`, `VUM=2`.
1. Reset, then 8 beats 0x01..0x08 with `in_last` on beat 8 and `out_ready=1` → `my_data_abv[0]={0x04,0x03,0x02,0x01}`, `[1]={0x08,0x07,0x06,0x05}`, `out_valid` for 1 cycle, no error pulses.
2. Same stimulus with `out_ready=0` for 5 cycles → `out_valid` and data stable for 5 cycles, `in_ready=0`, and a beat driven meanwhile is not stored.
3. `in_last` on beat 3 (0xA1, 0xA2, 0xA3) → `err_early_last` pulse, `[0]={0x00,0xA3,0xA2,0xA1}`, `[1]` all 0.
4. 8 beats with no `in_last` → `err_missing_last` pulse, frame presented intact.
5. Drive `rst_n=0` after beat 5, then send a fresh 8-beat frame → only the new data appears and the partial frame is never presented.
6. Back-to-back frames with `in_valid=1` and `out_ready=1` throughout → 9-cycle period, with `in_ready` low exactly one cycle per frame.
